// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus arbiter: FSM state encoding,
// default bus word width, field positions inside a bus word, and the
// two-way round-robin pick function used by lcd_rr_arb.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Bus word layout: {rs, rw, data[7:0]}
    localparam int BUS_W_DEF = 10;
    localparam int RS_BIT    = 9;
    localparam int RW_BIT    = 8;
    localparam int DATA_MSB  = 7;

    // One-hot pick between two requesters; ptr=1 favours requester 1 on a tie.
    function automatic logic [1:0] rr_pick(input logic r0, input logic r1, input logic ptr);
        logic [1:0] p;
        p = 2'b00;
        if (r0 && r1) begin
            p = ptr ? 2'b10 : 2'b01;
        end else if (r0) begin
            p = 2'b01;
        end else if (r1) begin
            p = 2'b10;
        end
        return p;
    endfunction

endpackage

// File: rtl/lcd_arbiter_if.sv
// Requester/LCD-side signal bundle of the LCD bus arbiter.
// master: the environment (requesters and LCD controller busy flag).
// slave : the arbiter itself.
interface lcd_arbiter_if #(
    parameter int BUS_W = lcd_pkg::BUS_W_DEF
) ();
    logic             req0;
    logic             req1;
    logic [BUS_W-1:0] word0;
    logic [BUS_W-1:0] word1;
    logic             gnt0;
    logic             gnt1;
    logic             lcd_busy;
    logic             lcd_enable;
    logic [BUS_W-1:0] lcd_bus;
    logic             idle;
    logic             err;

    modport master (
        output req0, req1, word0, word1, lcd_busy,
        input  gnt0, gnt1, lcd_enable, lcd_bus, idle, err
    );

    modport slave (
        input  req0, req1, word0, word1, lcd_busy,
        output gnt0, gnt1, lcd_enable, lcd_bus, idle, err
    );
endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin selector. The pick is combinational from the
// requests; the fairness pointer only moves when the owner accepts the
// pick (advance), and then points at the requester that did not win.
module lcd_rr_arb
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] pick
);
    logic ptr;

    assign pick = rr_pick(req0, req1, ptr);

    // Pointer register: after a grant to 0 favour 1, after a grant to 1 favour 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= pick[0];
        end
    end
endmodule

// File: rtl/lcd_arbiter.sv
// LCD bus arbiter: grants one of two requesters access to an LCD
// controller, drives the captured word with an enable strobe until the
// controller reports busy, then waits for busy to clear.
// Optional feature macro: LCD_ARB_TIMEOUT_EN -- abandon ISSUE after
// TIMEOUT cycles without busy and raise the sticky err flag.
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int BUS_W   = BUS_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_arbiter_if.slave bus
);
    state_t           state_q, state_nx;
    logic             enable_q, enable_nx;
    logic [BUS_W-1:0] lcd_bus_q, lcd_bus_nx;
    logic             gnt0_q, gnt0_nx;
    logic             gnt1_q, gnt1_nx;
    logic             idle_q, idle_nx;
    logic [1:0]       pick;
    logic             advance;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             err_q, err_nx;
`endif

    lcd_rr_arb u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .advance (advance),
        .pick    (pick)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nx   = state_q;
        enable_nx  = enable_q;
        lcd_bus_nx = lcd_bus_q;
        gnt0_nx    = 1'b0;
        gnt1_nx    = 1'b0;
        advance    = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
        cnt_nx     = cnt_q;
        err_nx     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.lcd_busy && (pick != 2'b00)) begin
                    advance    = 1'b1;
                    gnt0_nx    = pick[0];
                    gnt1_nx    = pick[1];
                    lcd_bus_nx = pick[1] ? bus.word1 : bus.word0;
                    enable_nx  = 1'b1;
                    state_nx   = ISSUE;
`ifdef LCD_ARB_TIMEOUT_EN
                    cnt_nx     = '0;
`endif
                end
            end
            ISSUE: begin
                if (bus.lcd_busy) begin
                    enable_nx = 1'b0;
                    state_nx  = WAIT_DONE;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    enable_nx = 1'b0;
                    err_nx    = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.lcd_busy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx  = IDLE;
                enable_nx = 1'b0;
            end
        endcase
        idle_nx = (state_nx == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            lcd_bus_q <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_nx;
            enable_q  <= enable_nx;
            lcd_bus_q <= lcd_bus_nx;
            gnt0_q    <= gnt0_nx;
            gnt1_q    <= gnt1_nx;
            idle_q    <= idle_nx;
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    // ISSUE watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nx;
            err_q <= err_nx;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.lcd_enable = enable_q;
    assign bus.lcd_bus    = lcd_bus_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_lcd_arbiter.sv
// Testbench for lcd_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transfer-level reference model.
module tb_lcd_arbiter;
    import lcd_pkg::*;

    localparam int BUS_W   = 10;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_arbiter_if #(.BUS_W(BUS_W)) ifc ();

    lcd_arbiter #(.BUS_W(BUS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one transfer at a time; a transfer starts when a
    // request is seen while nothing is in flight and the LCD is not busy,
    // ends its strobe when busy is seen, and completes when busy clears.
    bit               m_xfer;
    bit               m_strobe;
    int               m_last;
    int               m_cnt;
    int               m_w;
    logic             m_gnt0, m_gnt1, m_en, m_idle, m_err;
    logic [BUS_W-1:0] m_bus;

    initial begin
        m_xfer = 0; m_strobe = 0; m_last = 1; m_cnt = 0;
        m_gnt0 = 0; m_gnt1 = 0; m_en = 0; m_idle = 1; m_err = 0; m_bus = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_xfer = 0; m_strobe = 0; m_last = 1; m_cnt = 0;
            m_gnt0 = 0; m_gnt1 = 0; m_en = 0; m_idle = 1; m_err = 0; m_bus = '0;
        end else begin
            m_gnt0 = 0;
            m_gnt1 = 0;
            if (!m_xfer) begin
                if (!ifc.lcd_busy && (ifc.req0 || ifc.req1)) begin
                    if (ifc.req0 && ifc.req1) m_w = 1 - m_last;
                    else                      m_w = ifc.req1 ? 1 : 0;
                    m_last   = m_w;
                    m_xfer   = 1;
                    m_strobe = 1;
                    m_cnt    = 0;
                    m_en     = 1;
                    m_bus    = (m_w == 1) ? ifc.word1 : ifc.word0;
                    if (m_w == 1) m_gnt1 = 1; else m_gnt0 = 1;
                end
            end else if (m_strobe) begin
                if (ifc.lcd_busy) begin
                    m_strobe = 0;
                    m_en     = 0;
                end else begin
`ifdef LCD_ARB_TIMEOUT_EN
                    m_cnt++;
                    if (m_cnt == TIMEOUT) begin
                        m_strobe = 0;
                        m_xfer   = 0;
                        m_en     = 0;
                        m_err    = 1;
                    end
`endif
                end
            end else if (!ifc.lcd_busy) begin
                m_xfer = 0;
            end
            m_idle = !m_xfer;
        end
    end

    // Stimulus helpers: LCD busy responder and random requesters.
    bit               auto_busy = 0;
    bit               noise     = 0;
    bit               rand_req  = 0;
    int               rsp_ph    = 0;
    int               rsp_cnt   = 0;
    bit               prev_en   = 0;
    logic [BUS_W-1:0] prev_bus  = '0;

    task automatic compare_all();
        chk("gnt0",    ifc.gnt0,       m_gnt0);
        chk("gnt1",    ifc.gnt1,       m_gnt1);
        chk("enable",  ifc.lcd_enable, m_en);
        chk("lcd_bus", ifc.lcd_bus,    m_bus);
        chk("idle",    ifc.idle,       m_idle);
        chk("err",     ifc.err,        m_err);
        chk("gnt_mutex", ifc.gnt0 & ifc.gnt1, 0);
        if (prev_en && ifc.lcd_enable && !(ifc.gnt0 || ifc.gnt1))
            chk("bus_hold", ifc.lcd_bus, prev_bus);
        prev_en  = ifc.lcd_enable;
        prev_bus = ifc.lcd_bus;
    endtask

    task automatic respond();
        if (rsp_ph == 0) begin
            if (ifc.lcd_enable) begin
                rsp_ph  = 1;
                rsp_cnt = $urandom_range(0, 2);
            end else if (noise && $urandom_range(0, 7) == 0) begin
                ifc.lcd_busy = 1'b1;
                rsp_ph  = 2;
                rsp_cnt = $urandom_range(1, 3);
            end
        end
        if (rsp_ph == 1) begin
            if (rsp_cnt == 0) begin
                ifc.lcd_busy = 1'b1;
                rsp_ph  = 2;
                rsp_cnt = $urandom_range(1, 3);
            end else begin
                rsp_cnt--;
            end
        end else if (rsp_ph == 2) begin
            if (rsp_cnt == 0) begin
                ifc.lcd_busy = 1'b0;
                rsp_ph = 0;
            end else begin
                rsp_cnt--;
            end
        end
    endtask

    task automatic drive_reqs();
        if (ifc.req0) begin
            if (ifc.gnt0) begin
                if ($urandom_range(0, 1) == 0) ifc.req0 = 1'b0;
                ifc.word0 = BUS_W'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                ifc.req0 = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            ifc.req0  = 1'b1;
            ifc.word0 = BUS_W'($urandom);
        end
        if (ifc.req1) begin
            if (ifc.gnt1) begin
                if ($urandom_range(0, 1) == 0) ifc.req1 = 1'b0;
                ifc.word1 = BUS_W'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                ifc.req1 = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            ifc.req1  = 1'b1;
            ifc.word1 = BUS_W'($urandom);
        end
    endtask

    // One clock: let the edge happen, check at the falling edge, then
    // update the environment for the next edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (auto_busy) respond();
        if (rand_req)  drive_reqs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.lcd_busy = 1'b0;
        auto_busy = 0; noise = 0; rand_req = 0; rsp_ph = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_idle",   ifc.idle,       1);
        chk("rst_enable", ifc.lcd_enable, 0);
        chk("rst_bus",    ifc.lcd_bus,    0);
        chk("rst_gnt",    {ifc.gnt1, ifc.gnt0}, 0);
        chk("rst_err",    ifc.err,        0);
        rst_n   = 1'b1;
        prev_en = 0;
    endtask

    int               n;
    int               bad;
    int               gseq [4];
    logic [BUS_W-1:0] bseq [4];

    initial begin
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        ifc.word0 = '0;  ifc.word1 = '0;
        ifc.lcd_busy = 1'b0;

        // Single request with a hand-driven busy handshake.
        do_reset();
        ifc.word0 = 10'h238; ifc.req0 = 1'b1;
        tick();
        chk("single_gnt0",   ifc.gnt0,       1);
        chk("single_enable", ifc.lcd_enable, 1);
        chk("single_bus",    ifc.lcd_bus,    10'h238);
        ifc.req0 = 1'b0;
        ifc.word0 = 10'h0FF;
        tick();
        chk("single_hold", ifc.lcd_enable, 1);
        chk("single_word", ifc.lcd_bus,    10'h238);
        ifc.lcd_busy = 1'b1;
        tick();
        chk("single_drop", ifc.lcd_enable, 0);
        chk("single_wait", ifc.idle,       0);
        ifc.lcd_busy = 1'b0;
        tick();
        chk("single_idle", ifc.idle, 1);

        // Contention from reset: strict alternation starting with 0.
        do_reset();
        ifc.word0 = 10'h201; ifc.word1 = 10'h341;
        ifc.req0 = 1'b1; ifc.req1 = 1'b1;
        auto_busy = 1;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            tick();
            if (ifc.gnt0 || ifc.gnt1) begin
                gseq[n] = ifc.gnt1 ? 1 : 0;
                bseq[n] = ifc.lcd_bus;
                n++;
            end
        end
        chk("cont_count", n, 4);
        for (int k = 0; k < n; k++) begin
            chk("cont_order", gseq[k], k % 2);
            chk("cont_bus",   bseq[k], (k % 2 == 1) ? 10'h341 : 10'h201);
        end

        // Busy held for 100 cycles blocks any grant.
        do_reset();
        ifc.lcd_busy = 1'b1;
        ifc.word1 = 10'h155; ifc.req1 = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ifc.gnt1 || ifc.gnt0 || ifc.lcd_enable) bad++;
        end
        chk("busy_blocked", bad, 0);
        ifc.lcd_busy = 1'b0;
        tick();
        chk("busy_release_gnt1", ifc.gnt1,    1);
        chk("busy_release_bus",  ifc.lcd_bus, 10'h155);
        ifc.req1 = 1'b0;
        auto_busy = 1;
        for (int i = 0; i < 20 && !ifc.idle; i++) tick();
        chk("busy_back_idle", ifc.idle, 1);

`ifdef LCD_ARB_TIMEOUT_EN
        // Watchdog: busy never rises, strobe abandoned after TIMEOUT cycles.
        do_reset();
        ifc.word0 = 10'h0AA; ifc.req0 = 1'b1;
        tick();
        chk("to_gnt0", ifc.gnt0, 1);
        ifc.req0 = 1'b0;
        n = 0;
        while (ifc.lcd_enable && n < 40) begin
            n++;
            tick();
        end
        chk("to_len",  n,       TIMEOUT);
        chk("to_err",  ifc.err, 1);
        chk("to_idle", ifc.idle, 1);
        ifc.word1 = 10'h123; ifc.req1 = 1'b1;
        tick();
        chk("to_next_gnt1", ifc.gnt1, 1);
        chk("to_err_sticky", ifc.err, 1);
        ifc.req1 = 1'b0;
        auto_busy = 1;
        for (int i = 0; i < 20 && !ifc.idle; i++) tick();
        chk("to_err_kept", ifc.err, 1);
`endif

        // Asynchronous reset in the middle of a strobe.
        do_reset();
        ifc.word1 = 10'h3C3; ifc.req1 = 1'b1;
        tick();
        chk("mid_enable", ifc.lcd_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", ifc.lcd_enable, 0);
        chk("mid_rst_bus",    ifc.lcd_bus,    0);
        chk("mid_rst_idle",   ifc.idle,       1);
        @(negedge clk);
        ifc.word0 = 10'h0C3; ifc.req0 = 1'b1; ifc.req1 = 1'b1;
        rst_n = 1'b1;
        prev_en = 0;
        tick();
        chk("mid_after_gnt0", ifc.gnt0,    1);
        chk("mid_after_gnt1", ifc.gnt1,    0);
        chk("mid_after_bus",  ifc.lcd_bus, 10'h0C3);

        // Randomized traffic with a reactive busy model and busy noise.
        auto_busy = 1;
        noise     = 1;
        rand_req  = 1;
        for (int i = 0; i < 3000; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
